// File: rtl/proc_control.sv
// Instruction-sequencing control for the multicycle processor: latches a 9-bit
// instruction, steps T0..T3 and emits per-cycle datapath strobes.
module proc_control #(
  parameter int DW = 16  // DIN width, must be >= 9; instruction sits in the top 9 bits
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Run,
  input  logic [DW-1:0] DIN,
  output logic [2:0]    RinSel,
  output logic          RinEn,
  output logic [2:0]    RoutSel,
  output logic          RoutEn,
  output logic          IRin,
  output logic          DINout,
  output logic          Ain,
  output logic          Gin,
  output logic          Gout,
  output logic          AddSub,
  output logic          Done,
  output logic [2:0]    Opcode,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} state_t;

  state_t     state, state_next;
  logic [8:0] ir;
  logic [2:0] iii, xxx, yyy;

  assign iii = ir[8:6];
  assign xxx = ir[5:3];
  assign yyy = ir[2:0];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= T0;
      ir    <= 9'd0;
    end else begin
      state <= state_next;
      if (state == T0 && Run) ir <= DIN[DW-1 -: 9];
    end
  end

  // Outputs depend only on state and IR (plus Run for IRin); Reset masks them all.
  always_comb begin
    state_next = state;
    RinSel     = 3'd0;
    RinEn      = 1'b0;
    RoutSel    = 3'd0;
    RoutEn     = 1'b0;
    IRin       = 1'b0;
    DINout     = 1'b0;
    Ain        = 1'b0;
    Gin        = 1'b0;
    Gout       = 1'b0;
    AddSub     = 1'b0;
    Done       = 1'b0;
    Opcode     = iii;
    dbg_state  = state;
    case (state)
      T0: begin
        IRin       = Run;
        state_next = Run ? T1 : T0;
      end
      T1: begin
        state_next = T0;
        case (iii)
          3'b000: begin
            RoutSel = yyy;
            RoutEn  = 1'b1;
            RinSel  = xxx;
            RinEn   = 1'b1;
            Done    = 1'b1;
          end
          3'b001: begin
            DINout = 1'b1;
            RinSel = xxx;
            RinEn  = 1'b1;
            Done   = 1'b1;
          end
          3'b010, 3'b011: begin
            RoutSel    = xxx;
            RoutEn     = 1'b1;
            Ain        = 1'b1;
            state_next = T2;
          end
          default: Done = 1'b1;  // reserved opcodes retire as NOP
        endcase
      end
      T2: begin
        RoutSel    = yyy;
        RoutEn     = 1'b1;
        Gin        = 1'b1;
        AddSub     = iii[0];
        state_next = T3;
      end
      T3: begin
        Gout       = 1'b1;
        RinSel     = xxx;
        RinEn      = 1'b1;
        Done       = 1'b1;
        state_next = T0;
      end
      default: state_next = T0;
    endcase
    if (Reset) begin
      RinSel    = 3'd0;
      RinEn     = 1'b0;
      RoutSel   = 3'd0;
      RoutEn    = 1'b0;
      IRin      = 1'b0;
      DINout    = 1'b0;
      Ain       = 1'b0;
      Gin       = 1'b0;
      Gout      = 1'b0;
      AddSub    = 1'b0;
      Done      = 1'b0;
      Opcode    = 3'd0;
      dbg_state = 2'd0;
    end
  end

endmodule

// File: tb/tb_proc_control.sv
// Bench for proc_control: directed scenarios plus random traffic, checked
// against a per-instruction cycle-script model.
module tb_proc_control;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Run   = 1'b0;
  logic [15:0] DIN   = 16'd0;
  logic [2:0]  RinSel, RoutSel, Opcode;
  logic        RinEn, RoutEn, IRin, DINout, Ain, Gin, Gout, AddSub, Done;
  logic [1:0]  dbg_state;

  proc_control #(.DW(16)) dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .DIN(DIN),
    .RinSel(RinSel), .RinEn(RinEn), .RoutSel(RoutSel), .RoutEn(RoutEn),
    .IRin(IRin), .DINout(DINout), .Ain(Ain), .Gin(Gin), .Gout(Gout),
    .AddSub(AddSub), .Done(Done), .Opcode(Opcode), .dbg_state(dbg_state)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [2:0] rinsel;
    logic       rinen;
    logic [2:0] routsel;
    logic       routen;
    logic       irin, dinout, ain, gin, gout, addsub, done;
    logic [2:0] opcode;
    logic [1:0] st;
  } outs_t;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  outs_t      sched[$];   // expected outputs for the remaining cycles of the current instruction
  logic [8:0] m_ir = 9'd0;

  task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%05h exp=%05h", tag, got, exp);
    end
  endtask

  // Expected per-cycle behaviour of one instruction after its T0 cycle.
  task automatic push_instr(input logic [8:0] ir);
    outs_t c;
    logic [2:0] op, x, y;
    op = ir[8:6]; x = ir[5:3]; y = ir[2:0];
    c = '0; c.opcode = op; c.st = 2'd1;
    if (op == 3'b000) begin
      c.routsel = y; c.routen = 1; c.rinsel = x; c.rinen = 1; c.done = 1;
      sched.push_back(c);
    end else if (op == 3'b001) begin
      c.dinout = 1; c.rinsel = x; c.rinen = 1; c.done = 1;
      sched.push_back(c);
    end else if (op[2] == 1'b0) begin
      c.routsel = x; c.routen = 1; c.ain = 1;
      sched.push_back(c);
      c = '0; c.opcode = op; c.st = 2'd2;
      c.routsel = y; c.routen = 1; c.gin = 1; c.addsub = op[0];
      sched.push_back(c);
      c = '0; c.opcode = op; c.st = 2'd3;
      c.gout = 1; c.rinsel = x; c.rinen = 1; c.done = 1;
      sched.push_back(c);
    end else begin
      c.done = 1;
      sched.push_back(c);
    end
  endtask

  function automatic logic model_idle();
    return sched.size() == 0;
  endfunction

  task automatic step(input string tag, input logic rst, input logic run, input logic [15:0] din);
    outs_t exp, got;
    int drivers;
    @(negedge Clock);
    Reset = rst; Run = run; DIN = din;
    #2;
    exp = '0;
    if (!rst) begin
      if (sched.size() == 0) begin
        exp.irin = run;
        exp.opcode = m_ir[8:6];
      end else begin
        exp = sched[0];
      end
    end
    got = {RinSel, RinEn, RoutSel, RoutEn, IRin, DINout, Ain, Gin, Gout, AddSub, Done, Opcode, dbg_state};
    check(tag, got, exp);
    drivers = int'(RoutEn) + int'(DINout) + int'(Gout);
    check({tag, "_onedrv"}, 20'(drivers <= 1), 20'd1);
    if (Done) done_seen++;
    if (rst) begin
      sched.delete();
      m_ir = 9'd0;
    end else if (sched.size() == 0) begin
      if (run) begin
        m_ir = din[15:7];
        push_instr(m_ir);
      end
    end else begin
      void'(sched.pop_front());
    end
  endtask

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y);
    return {op, x, y, 7'd0};
  endfunction

  initial begin
    logic [15:0] prog[3];
    int k;
    // Reset beats Run; IR must stay clear.
    step("rst_run", 1, 1, 16'h1234);
    step("rst_after", 0, 0, 16'h0000);

    // mv R3,R5
    step("mv_t0", 0, 1, 16'h0EA0);
    step("mv_t1", 0, 0, 16'h0000);
    step("mv_idle", 0, 0, 16'h0000);

    // mvi R7
    step("mvi_t0", 0, 1, 16'h3C00);
    step("mvi_t1", 0, 0, 16'hFFFF);

    // sub R1,R2
    step("sub_t0", 0, 1, 16'h6500);
    step("sub_t1", 0, 1, 16'hFFFF);
    step("sub_t2", 0, 1, 16'hFFFF);
    step("sub_t3", 0, 0, 16'hFFFF);
    step("sub_idle", 0, 0, 16'h0000);

    // Back-to-back add, mv, NOP with Run held: exactly 8 cycles, 3 Done pulses.
    prog[0] = enc(3'b010, 3'd4, 3'd6);
    prog[1] = enc(3'b000, 3'd2, 3'd1);
    prog[2] = enc(3'b100, 3'd7, 3'd7);
    k = 0;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (model_idle()) begin
        step("chain", 0, 1, prog[k % 3]);
        k++;
      end else begin
        step("chain", 0, 1, 16'(($urandom)));
      end
    end
    check("chain_issued", 20'(k), 20'd3);
    check("chain_done", 20'(done_seen), 20'd3);
    step("chain_end", 0, 0, 16'h0000);

    // Reset during T2 of an add aborts it; a later mv runs normally.
    done_seen = 0;
    step("ab_t0", 0, 1, enc(3'b010, 3'd5, 3'd3));
    step("ab_t1", 0, 0, 16'h0000);
    step("ab_rst", 1, 0, 16'h0000);
    step("ab_after", 0, 0, 16'h0000);
    check("ab_nodone", 20'(done_seen), 20'd0);
    step("ab_mv_t0", 0, 1, enc(3'b000, 3'd6, 3'd2));
    step("ab_mv_t1", 0, 0, 16'h0000);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step("rand", ($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1, 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
